// File: rtl/bin_to_ex3_seq_pkg.sv
// Shared constants, state encoding and the digit-adjust helper for the
// binary-to-decimal (BCD / excess-3) sequential converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] EX3_BIAS   = 4'd3;
  localparam logic [3:0] ADJ_THRESH = 4'd5;

  // Double-dabble correction: a digit of 5 or more would exceed 9 once
  // doubled, so pre-bias it by 3 to make the carry land in the next digit.
  function automatic logic [3:0] add3_adj(input logic [3:0] digit);
    return (digit >= ADJ_THRESH) ? digit + EX3_BIAS : digit;
  endfunction

endpackage

// File: rtl/bin_to_ex3_seq_if.sv
// Start/busy/done handshake plus operand and result bus of the converter.
interface bin_to_ex3_seq_if #(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
);
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                mode;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   dout;
  logic                ovf;

  modport master (output start, bin_in, mode, input busy, done, dout, ovf);
  modport slave  (input start, bin_in, mode, output busy, done, dout, ovf);
endinterface

// File: rtl/bin_to_ex3_seq_digit_adj.sv
// Combinational "if >= 5 add 3" correction for one BCD digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);
  assign adj = add3_adj(digit);
endmodule

// File: rtl/bin_to_ex3_seq.sv
// Iterative binary to NDIG-digit decimal converter (double dabble), one bit
// per cycle, emitting packed BCD or excess-3 per conversion.
module bin_to_ex3_seq
  import bcd_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NDIG  = 3,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  bin_to_ex3_seq_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] SHIFT = 2'(ST_SHIFT);
  localparam logic [1:0] DONE  = 2'(ST_DONE);

  logic [1:0]          state;
  logic [WIDTH-1:0]    binreg;
  logic [4*NDIG-1:0]   digits;
  logic [4*NDIG-1:0]   adj;
  logic [4*NDIG-1:0]   ex3;
  logic [4*NDIG-1:0]   dout_q;
  logic [CW-1:0]       cnt;
  logic                mode_q;
  logic                ovf_sticky;
  logic                ovf_q;
  logic                busy_q;
  logic                done_q;

  // Per-digit adjust cells and the excess-3 view of the finished digits.
  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    bcd_digit_adj u_adj (
      .digit (digits[4*k +: 4]),
      .adj   (adj[4*k +: 4])
    );
    assign ex3[4*k +: 4] = digits[4*k +: 4] + EX3_BIAS;
  end

  // Control FSM plus the {digits, binreg} shift register and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      binreg     <= '0;
      digits     <= '0;
      cnt        <= '0;
      mode_q     <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_q      <= 1'b0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            binreg     <= bus.bin_in;
            mode_q     <= bus.mode;
            digits     <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            busy_q     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // A set bit 3 in the adjusted top digit is about to fall off the
          // end: the value no longer fits in NDIG digits.
          if (adj[4*NDIG-1]) ovf_sticky <= 1'b1;
          {digits, binreg} <= {adj[4*NDIG-2:0], binreg, 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          dout_q <= mode_q ? ex3 : digits;
          ovf_q  <= ovf_sticky;
          done_q <= 1'b1;
          busy_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_ex3_seq.sv
// Directed bench for bin_to_ex3_seq: three builds (8b/3 digits, 8b/2 digits,
// 1b/1 digit) share clock and reset.
module tb_bin_to_ex3_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bin_to_ex3_seq_if #(.WIDTH(8), .NDIG(3)) b3 ();
  bin_to_ex3_seq_if #(.WIDTH(8), .NDIG(2)) b2 ();
  bin_to_ex3_seq_if #(.WIDTH(1), .NDIG(1)) b1 ();

  bin_to_ex3_seq #(.WIDTH(8), .NDIG(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  bin_to_ex3_seq #(.WIDTH(8), .NDIG(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  bin_to_ex3_seq #(.WIDTH(1), .NDIG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of v (low nd digits), optionally biased by 3.
  function automatic logic [11:0] model(input int v, input logic m, input int nd);
    logic [11:0] d;
    int x;
    int dig;
    d = '0;
    x = v;
    for (int k = 0; k < nd; k++) begin
      dig = x % 10;
      x   = x / 10;
      d[4*k +: 4] = 4'(m ? dig + 3 : dig);
    end
    return d;
  endfunction

  function automatic int ndig_of(input int sel);
    return (sel == 0) ? 3 : (sel == 1) ? 2 : 1;
  endfunction

  task automatic set_in(input int sel, input logic s, input logic [7:0] v, input logic m);
    case (sel)
      0:       begin b3.start = s; b3.bin_in = v;    b3.mode = m; end
      1:       begin b2.start = s; b2.bin_in = v;    b2.mode = m; end
      default: begin b1.start = s; b1.bin_in = v[0]; b1.mode = m; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? b3.done : (sel == 1) ? b2.done : b1.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? b3.busy : (sel == 1) ? b2.busy : b1.busy;
  endfunction

  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? b3.ovf : (sel == 1) ? b2.ovf : b1.ovf;
  endfunction

  function automatic logic [11:0] get_dout(input int sel);
    return (sel == 0) ? b3.dout : (sel == 1) ? {4'h0, b2.dout} : {8'h0, b1.dout};
  endfunction

  // Count negedges after the start-drop negedge until done; -1 on timeout.
  task automatic wait_done(input int sel, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (get_done(sel)) begin
        lat = i;
        break;
      end
    end
  endtask

  // One full conversion with result, overflow, busy and single-pulse checks.
  task automatic run(input int sel, input int v, input logic m, input string tag,
                     input int exp_lat);
    int lat;
    int nd;
    int lim;
    nd  = ndig_of(sel);
    lim = (nd == 3) ? 999 : (nd == 2) ? 99 : 9;
    @(negedge clk);
    set_in(sel, 1'b1, 8'(v), m);
    @(posedge clk);
    @(negedge clk);
    set_in(sel, 1'b0, 8'(v), m);
    wait_done(sel, lat);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    else if (lat < 0) chk({tag, "_timeout"}, lat, 0);
    chk({tag, "_dout"}, {20'h0, get_dout(sel)}, {20'h0, model(v, m, nd)});
    chk({tag, "_ovf"}, {31'h0, get_ovf(sel)}, {31'h0, (v > lim)});
    chk({tag, "_busy"}, {31'h0, get_busy(sel)}, 32'h1);
    @(negedge clk);
    chk({tag, "_done_once"}, {31'h0, get_done(sel)}, 32'h0);
  endtask

  initial begin
    int lat;
    int seen;
    set_in(0, 1'b0, 8'h0, 1'b0);
    set_in(1, 1'b0, 8'h0, 1'b0);
    set_in(2, 1'b0, 8'h0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, b3.busy}, 32'h0);
    chk("rst_done", {31'h0, b3.done}, 32'h0);
    chk("rst_dout", {20'h0, b3.dout}, 32'h0);
    chk("rst_ovf",  {31'h0, b3.ovf},  32'h0);
    rst_n = 1'b1;

    // Zero and full-scale, both codes
    run(0, 0,   1'b1, "z_ex3", 9);
    run(0, 0,   1'b0, "z_bcd", 9);
    run(0, 255, 1'b0, "max_bcd", 9);
    chk("max_bcd_raw", {20'h0, b3.dout}, 32'h255);
    run(0, 255, 1'b1, "max_ex3", 9);
    chk("max_ex3_raw", {20'h0, b3.dout}, 32'h588);

    // Two-digit build: overflow and edge of range
    run(1, 123, 1'b0, "n2_123", 9);
    chk("n2_123_raw", {24'h0, b2.dout}, 32'h23);
    run(1, 99, 1'b0, "n2_99", 9);
    run(1, 99, 1'b1, "n2_99x", 9);
    chk("n2_99x_raw", {24'h0, b2.dout}, 32'hCC);
    run(1, 200, 1'b1, "n2_200x", 9);

    // Single-bit build: exactly one shift cycle
    run(2, 1, 1'b1, "w1_1x", 2);
    run(2, 1, 1'b0, "w1_1", 2);
    run(2, 0, 1'b1, "w1_0x", 2);

    // Start held through busy: ignored until IDLE, then taken once
    @(negedge clk);
    set_in(0, 1'b1, 8'd37, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b1, 8'd200, 1'b0);
    wait_done(0, lat);
    chk("hold_lat",  lat, 9);
    chk("hold_dout", {20'h0, b3.dout}, 32'h037);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 8'd200, 1'b0);
    chk("hold_done_once", {31'h0, b3.done}, 32'h0);
    chk("hold_busy2", {31'h0, b3.busy}, 32'h1);
    wait_done(0, lat);
    chk("hold2_lat",  lat, 9);
    chk("hold2_dout", {20'h0, b3.dout}, 32'h200);
    @(negedge clk);

    // Reset during SHIFT aborts with everything cleared and no done
    run(1, 150, 1'b0, "pre_rst", 9);
    @(negedge clk);
    set_in(0, 1'b1, 8'd77, 1'b0);
    set_in(1, 1'b1, 8'd50, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 8'd77, 1'b0);
    set_in(1, 1'b0, 8'd50, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, b3.busy}, 32'h0);
    chk("arst_done", {31'h0, b3.done}, 32'h0);
    chk("arst_dout", {20'h0, b3.dout}, 32'h0);
    chk("arst_ovf2", {31'h0, b2.ovf},  32'h0);
    chk("arst_dout2", {24'h0, b2.dout}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (b3.done || b2.done || b3.busy) seen++;
    end
    chk("arst_nodone", seen, 0);
    run(0, 77, 1'b1, "post_rst", 9);

    // Sweep of the whole 8-bit range in both codes
    for (int v = 0; v < 256; v++) begin
      run(0, v, 1'b0, "sw_bcd", 0);
      run(0, v, 1'b1, "sw_ex3", 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
